adder_seq_n: RTL and testbench

Multi-cycle, parametrised N-bit adder/subtractor that processes its operands W bits per clock through a single W-bit `adder_n` slice, carrying between chunks in a register. It is the area-reduced, sequential successor to the combinational `adder_n`: it trades latency for a short critical path and adds a subtract mode plus carry, signed-overflow and zero flags. It serves as the arithmetic unit for multi-cycle datapaths with a start/done handshake.

---
 rtl/adder_seq_n.sv | 150 +++++++++++++++
 tb/tb_adder_seq_n.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_n.sv
// Sequential N-bit adder/subtractor: W bits per clock through one adder_n slice,
// with a start/done handshake and carry, signed-overflow and zero flags.

module adder_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
endmodule

module adder_seq_n #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow,
    output logic         zero
);
    localparam int K  = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    generate
        if ((N % W) != 0) begin : g_bad_cfg
            $error("adder_seq_n: N must be a multiple of W");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [N-1:0]    a_reg, b_reg;
    logic            carry_reg;
    logic [N-1:0]    sum_reg, sum_next;
    logic            busy_reg, done_reg;
    logic            c_out_reg, overflow_reg, zero_reg;

    logic [W-1:0]    a_chunks [K];
    logic [W-1:0]    b_chunks [K];
    logic [W-1:0]    a_chunk, b_chunk, slice_sum;
    logic            slice_c;
    logic            last_chunk;

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_chunk
            assign a_chunks[gi] = a_reg[gi*W +: W];
            assign b_chunks[gi] = b_reg[gi*W +: W];
        end
    endgenerate

    adder_n #(.N(W)) u_slice (
        .a     (a_chunk),
        .b     (b_chunk),
        .c_in  (carry_reg),
        .sum   (slice_sum),
        .c_out (slice_c)
    );

    assign last_chunk = (cnt_reg == CW'(K - 1));

    // Chunk select and the merged result with the current chunk dropped in,
    // so the zero flag can be taken from the complete word on the final edge.
    always_comb begin
        a_chunk  = '0;
        b_chunk  = '0;
        sum_next = sum_reg;
        for (int k = 0; k < K; k++) begin
            if (cnt_reg == CW'(k)) begin
                a_chunk             = a_chunks[k];
                b_chunk             = b_chunks[k];
                sum_next[k*W +: W]  = slice_sum;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_chunk) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            carry_reg    <= 1'b0;
            sum_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            c_out_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == S_RUN);
            done_reg  <= (state_next == S_DONE);
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : c_in;
                        cnt_reg   <= '0;
                    end
                end
                S_RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= slice_c;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_chunk) begin
                        c_out_reg    <= slice_c;
                        overflow_reg <= (a_reg[N-1] == b_reg[N-1]) &&
                                        (sum_next[N-1] != a_reg[N-1]);
                        zero_reg     <= (sum_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign sum      = sum_reg;
    assign c_out    = c_out_reg;
    assign overflow = overflow_reg;
    assign zero     = zero_reg;

endmodule

// File: tb/tb_adder_seq_n.sv
// Randomised and directed bench for adder_seq_n over four (N,W) configurations,
// checked against a plain-arithmetic model of add/subtract with flags.

module tb_adder_seq_n;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_m = 1'b0;
    logic        start_x = 1'b0;
    logic        sub = 1'b0;
    logic        c_in = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        busy_v  [4];
    logic        done_v  [4];
    logic        c_out_v [4];
    logic        ov_v    [4];
    logic        zero_v  [4];
    logic [31:0] sum_v   [4];
    logic [15:0] sum_h;

    int total = 0;
    int bad   = 0;
    int kk [4] = '{4, 32, 1, 4};
    int nn [4] = '{32, 32, 32, 16};

    always #5 clk = ~clk;

    assign sum_v[3] = {16'h0, sum_h};

    adder_seq_n #(.N(32), .W(8)) u_m (
        .clk(clk), .rst(rst), .start(start_m), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .c_out(c_out_v[0]),
        .overflow(ov_v[0]), .zero(zero_v[0]));

    adder_seq_n #(.N(32), .W(1)) u_bit (
        .clk(clk), .rst(rst), .start(start_x), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .c_out(c_out_v[1]),
        .overflow(ov_v[1]), .zero(zero_v[1]));

    adder_seq_n #(.N(32), .W(32)) u_wide (
        .clk(clk), .rst(rst), .start(start_x), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .c_out(c_out_v[2]),
        .overflow(ov_v[2]), .zero(zero_v[2]));

    adder_seq_n #(.N(16), .W(4)) u_half (
        .clk(clk), .rst(rst), .start(start_x), .sub(sub), .a(a[15:0]), .b(b[15:0]), .c_in(c_in),
        .busy(busy_v[3]), .done(done_v[3]), .sum(sum_h), .c_out(c_out_v[3]),
        .overflow(ov_v[3]), .zero(zero_v[3]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: n-bit unsigned/signed arithmetic on 64-bit integers.
    function automatic void model(input int n, input logic [31:0] ua, input logic [31:0] ub,
                                  input logic s, input logic ci,
                                  output logic [31:0] r, output logic [2:0] fl);
        longint one  = 1;
        longint mod  = one << n;
        longint half = one << (n - 1);
        longint a0   = longint'(ua) & (mod - 1);
        longint b0   = longint'(ub) & (mod - 1);
        longint sa   = (a0 >= half) ? a0 - mod : a0;
        longint sb   = (b0 >= half) ? b0 - mod : b0;
        longint res, ss;
        logic   co, ov;
        if (s) begin
            res = (a0 - b0 + mod) % mod;
            co  = (a0 >= b0);
            ss  = sa - sb;
        end else begin
            res = a0 + b0 + longint'(ci);
            co  = (res >= mod);
            res = res % mod;
            ss  = sa + sb + longint'(ci);
        end
        ov = (ss >= half) || (ss < -half);
        r  = res[31:0];
        fl = {co, ov, (res == 0)};
    endfunction

    // One operation on all four DUTs; inputs are scrambled after acceptance.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                          input logic ts, input logic tci);
        int          dcyc [4];
        int          nd   [4];
        int          nb   [4];
        int          ovl  [4];
        logic [31:0] rs   [4];
        logic [2:0]  rf   [4];
        logic [31:0] er;
        logic [2:0]  ef;
        for (int d = 0; d < 4; d++) begin
            dcyc[d] = 0; nd[d] = 0; nb[d] = 0; ovl[d] = 0; rs[d] = '0; rf[d] = '0;
        end
        @(negedge clk);
        a = ta; b = tb; sub = ts; c_in = tci; start_m = 1'b1; start_x = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (busy_v[d]) nb[d]++;
                if (busy_v[d] && done_v[d]) ovl[d]++;
                if (done_v[d]) begin
                    nd[d]++;
                    if (dcyc[d] == 0) dcyc[d] = c;
                    rs[d] = sum_v[d];
                    rf[d] = {c_out_v[d], ov_v[d], zero_v[d]};
                end
            end
            if (c == 1) begin
                start_m = 1'b0; start_x = 1'b0;
                a = $urandom; b = $urandom; sub = ~ts; c_in = ~tci;
            end
        end
        for (int d = 0; d < 4; d++) begin
            model(nn[d], ta, tb, ts, tci, er, ef);
            check($sformatf("timing[%0d]", d),
                  {16'(dcyc[d]), 16'(nd[d]), 16'(nb[d]), 16'(ovl[d])},
                  {16'(kk[d] + 1), 16'd1, 16'(kk[d]), 16'd0});
            check($sformatf("sum[%0d] %h%s%h", d, ta, ts ? "-" : "+", tb), 64'(rs[d]), 64'(er));
            check($sformatf("flags[%0d] c,v,z", d), 64'(rf[d]), 64'(ef));
        end
        $display("op %h %s %h cin=%0d -> sum=%h c=%0d v=%0d z=%0d",
                 ta, ts ? "-" : "+", tb, tci, rs[0], rf[0][2], rf[0][1], rf[0][0]);
    endtask

    task automatic check_cleared(input string tag);
        for (int d = 0; d < 4; d++)
            check($sformatf("%s[%0d]", tag, d),
                  {27'h0, busy_v[d], done_v[d], c_out_v[d], ov_v[d], zero_v[d], sum_v[d]}, 64'h0);
    endtask

    initial begin
        int          dn;
        int          dc [2];
        logic [31:0] ds [2];
        logic        dco [2];
        logic [31:0] er;
        logic [2:0]  ef;
        logic [31:0] ra, rb;

        repeat (3) @(negedge clk);
        check_cleared("reset_state");
        rst = 1'b0;

        run_op(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        run_op(32'h5, 32'h7, 1'b1, 1'b0);
        run_op(32'h7, 32'h5, 1'b1, 1'b1);
        run_op(32'h8000_0000, 32'h1, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(32'h0, 32'h0, 1'b1, 1'b1);

        // Handshake on the K=4 instance: starts in cycles 2 and 5 ignored, cycle 6 accepted.
        dn = 0; dc[0] = 0; dc[1] = 0; ds[0] = '0; ds[1] = '0; dco[0] = 0; dco[1] = 0;
        @(negedge clk);
        a = 32'h1; b = 32'h2; sub = 1'b0; c_in = 1'b0; start_m = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done_v[0]) begin
                if (dn < 2) begin
                    dc[dn] = c; ds[dn] = sum_v[0]; dco[dn] = c_out_v[0];
                end
                dn++;
            end
            if (c == 7) check("hs_busy_after_restart", 64'(busy_v[0]), 64'd1);
            start_m = (c == 2 || c == 5 || c == 6);
            if (c == 1) begin a = 32'hAAAA_AAAA; b = 32'hAAAA_AAAA; end
        end
        start_m = 1'b0;
        check("hs_done_count", 64'(dn), 64'd2);
        check("hs_first_done_cycle", 64'(dc[0]), 64'd5);
        check("hs_first_sum", 64'(ds[0]), 64'd3);
        check("hs_second_done_cycle", 64'(dc[1]), 64'd11);
        check("hs_second_sum", 64'(ds[1]), 64'h5555_5554);
        check("hs_second_cout", 64'(dco[1]), 64'd1);
        $display("handshake: dones=%0d at %0d,%0d sums=%h,%h", dn, dc[0], dc[1], ds[0], ds[1]);

        // Reset in cycle 2 aborts every instance with no done afterwards.
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; c_in = 1'b0;
        start_m = 1'b1; start_x = 1'b1;
        @(negedge clk);
        start_m = 1'b0; start_x = 1'b0;
        @(negedge clk);
        rst = 1'b1; start_m = 1'b1; start_x = 1'b1;
        @(negedge clk);
        rst = 1'b0; start_m = 1'b0; start_x = 1'b0;
        check_cleared("abort_cleared");
        dn = 0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) if (done_v[d] || busy_v[d]) dn++;
        end
        check("abort_no_activity", 64'(dn), 64'd0);
        $display("reset abort: activity after reset=%0d", dn);
        run_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b1);

        for (int i = 0; i < 500; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'hFFFF_FFFF;
                1: rb = 32'h8000_0000;
                2: rb = ra;
                3: rb = ~ra;
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        model(32, 32'h1, 32'h1, 1'b1, 1'b0, er, ef);
        check("model_sanity_zero_flag", 64'(ef[0]), 64'(er == 32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
